// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined add/subtract unit. An n-bit operation is split into k-bit chunks
// and each pipeline stage adds one chunk, passing its carry to the next stage.
// One operation per cycle is accepted under a valid/ready handshake, and the
// whole pipeline stalls together under backpressure.
//
// Parameters:
//   n  operand/result width (default 32)
//   k  chunk width per stage (default 8). n must be a multiple of k.
//      k == n gives a single-stage registered adder.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   in_valid   A, B, sub carry an operation this cycle
//   in_ready   unit accepts an operation this cycle
//   A, B       operands
//   sub        0: C = A + B, 1: C = A - B
//   out_valid  C, cout, ovf carry a result
//   out_ready  consumer takes the result this cycle
//   C          result
//   cout       carry out of bit n-1 (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//
// Build option:
//   ADDER_PIPE_SAT_EN  when defined, C saturates to the signed limit whose
//                      sign matches A whenever ovf is set. cout and ovf still
//                      describe the unsaturated result. When undefined, C
//                      wraps modulo 2^n.
// -----------------------------------------------------------------------------
module adder_pipe #(
    parameter int n = 32,
    parameter int k = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] C,
    output logic         cout,
    output logic         ovf
);

    localparam int STAGES = n / k;

    if ((k < 1) || (n % k != 0)) begin : g_param_err
        $error("adder_pipe: n (%0d) must be a positive multiple of k (%0d)", n, k);
    end

    // Single advance enable for the whole pipeline: everything moves together
    // or everything holds, so bubbles and data shift alike.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Each stage s register holds:
    //   v_q  valid bit
    //   w_q  result chunks 0..s in the low bits, untouched A chunks above
    //   c_q  carry out of chunk s
    //   b_q  B' chunks still to be consumed (absent in the last stage)
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int BW = n - s * k;  // B' bits still travelling at entry

        logic          v_in;
        logic [n-1:0]  w_in;
        logic [BW-1:0] b_in;
        logic          c_in;
        logic [k:0]    chunk_sum;
        logic [n-1:0]  w_nxt;

        logic          v_q;
        logic [n-1:0]  w_q;
        logic          c_q;

        if (s == 0) begin : g_first
            // Subtraction is A + ~B + 1: invert B and feed sub as carry-in.
            assign v_in = in_valid && en;
            assign w_in = A;
            assign b_in = sub ? ~B : B;
            assign c_in = sub;
        end else begin : g_next
            assign v_in = g_stage[s-1].v_q;
            assign w_in = g_stage[s-1].w_q;
            assign b_in = g_stage[s-1].g_mid.b_q;
            assign c_in = g_stage[s-1].c_q;
        end

        assign chunk_sum = {1'b0, w_in[s*k +: k]} + {1'b0, b_in[k-1:0]} + {{k{1'b0}}, c_in};

        always_comb begin
            w_nxt            = w_in;
            w_nxt[s*k +: k]  = chunk_sum[k-1:0];
        end

        if (s == STAGES - 1) begin : g_last
            logic         msb_cin;
            logic         ovf_nxt;
            logic [n-1:0] c_nxt;
            logic         ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit:
            // sum = a ^ b ^ cin  =>  cin = sum ^ a ^ b.
            assign msb_cin = w_nxt[n-1] ^ w_in[n-1] ^ b_in[BW-1];
            assign ovf_nxt = msb_cin ^ chunk_sum[k];

`ifdef ADDER_PIPE_SAT_EN
            // w_in[n-1] is still the original A sign bit at this point.
            assign c_nxt = ovf_nxt ? {w_in[n-1], {(n-1){~w_in[n-1]}}} : w_nxt;
`else
            assign c_nxt = w_nxt;
`endif

            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous stage's value from before the edge.
            // NOTE: data registers are reset too, not only valid bits, because
            // C/cout/ovf are driven straight from them and must read 0 in reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q   <= 1'b0;
                    w_q   <= '0;
                    c_q   <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (en) begin
                    v_q   <= v_in;
                    w_q   <= c_nxt;
                    c_q   <= chunk_sum[k];
                    ovf_q <= ovf_nxt;
                end
            end
        end else begin : g_mid
            logic [BW-k-1:0] b_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v_q <= 1'b0;
                    w_q <= '0;
                    c_q <= 1'b0;
                    b_q <= '0;
                end else if (en) begin
                    v_q <= v_in;
                    w_q <= w_nxt;
                    c_q <= chunk_sum[k];
                    b_q <= b_in[BW-1:k];
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_q;
    assign C         = g_stage[STAGES-1].w_q;
    assign cout      = g_stage[STAGES-1].c_q;
    assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//
// Self-checking bench for adder_pipe. Main instance uses the defaults
// (n=32, k=8, four stages); a second instance uses n=16, k=16 (one stage).
// Expected values for directed cases are written out by hand; the streaming
// case uses a whole-word arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [31:0] a, b, c;

    logic        in_valid2, in_ready2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [15:0] a2, b2, c2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .C(c), .cout(cout), .ovf(ovf)
    );

    adder_pipe #(.n(16), .k(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .A(a2), .B(b2), .sub(sub2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .C(c2), .cout(cout2), .ovf(ovf2)
    );

`ifdef ADDER_PIPE_SAT_EN
    localparam logic [31:0] EXP_ADD_OVF = 32'h7FFF_FFFF;
    localparam logic [31:0] EXP_SUB_OVF = 32'h8000_0000;
`else
    localparam logic [31:0] EXP_ADD_OVF = 32'h8000_0000;
    localparam logic [31:0] EXP_SUB_OVF = 32'h7FFF_FFFF;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: returns {ovf, cout, C} using whole-word arithmetic.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [32:0] t;
        logic [31:0] r;
        logic        co;
        logic        ov;
        if (s) begin
            t  = {1'b0, x} - {1'b0, y};
            co = ~t[32];
        end else begin
            t  = {1'b0, x} + {1'b0, y};
            co = t[32];
        end
        r  = t[31:0];
        ov = s ? ((x[31] != y[31]) && (r[31] != x[31]))
               : ((x[31] == y[31]) && (r[31] != x[31]));
`ifdef ADDER_PIPE_SAT_EN
        if (ov) r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {ov, co, r};
    endfunction

    // One isolated operation on the default instance: checks latency and result.
    task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic s, input logic [31:0] ec, input logic eco, input logic eov);
        int lat;
        a = x; b = y; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, lat, 4);
        check({tag, ".C"},       c,    ec);
        check({tag, ".cout"},    cout, eco);
        check({tag, ".ovf"},     ovf,  eov);
        tick();
        check({tag, ".drained"}, out_valid, 0);
    endtask

    logic [31:0] sa [10];
    logic [31:0] sb [10];
    logic        ss [10];
    logic [33:0] q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          idx;
        int          got_n;
        int          seen;
        logic [31:0] x;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; out_ready2 = 1'b1;

        // Reset state
        #12;
        check("reset.out_valid", out_valid, 0);
        check("reset.C",         c,         0);
        check("reset.cout",      cout,      0);
        check("reset.ovf",       ovf,       0);
        check("reset.in_ready",  in_ready,  1);
        check("reset16.out_valid", out_valid2, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Directed single operations
        run_op("add_ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, EXP_ADD_OVF,   1'b0, 1'b1);
        run_op("sub_neg",      32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b1, EXP_SUB_OVF,   1'b1, 1'b1);
        run_op("add_plain",    32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0);
        run_op("sub_equal",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000, 1'b1, 1'b0);

        // Ten back-to-back ops with a three-cycle output stall
        x = 32'h1357_9BDF;
        for (int i = 0; i < 10; i++) begin
            x = x * 32'd1103515245 + 32'd12345;
            sa[i] = x;
            x = x * 32'd1103515245 + 32'd12345;
            sb[i] = x;
            ss[i] = i[0];
        end
        idx = 0;
        got_n = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            in_valid  = (idx < 10);
            if (idx < 10) begin
                a = sa[idx]; b = sb[idx]; sub = ss[idx];
            end
            #1;
            if (cyc <= 12)
                check($sformatf("stream.in_ready[%0d]", cyc), in_ready, !(cyc >= 6 && cyc <= 8));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check($sformatf("stream.spurious[%0d]", cyc), out_valid, 0);
                end else begin
                    check($sformatf("stream.C[%0d]", got_n),    c,    q[0][31:0]);
                    check($sformatf("stream.cout[%0d]", got_n), cout, q[0][32]);
                    check($sformatf("stream.ovf[%0d]", got_n),  ovf,  q[0][33]);
                    if (out_ready) begin
                        void'(q.pop_front());
                        got_n++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub));
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("stream.count",     got_n,     10);
        check("stream.leftover",  q.size(),  0);
        check("stream.idle",      out_valid, 0);

        // Asynchronous reset with ops in flight and a stalled output
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + i; b = 32'h10; sub = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        check("rst_mid.pre_valid", out_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid.out_valid", out_valid, 0);
        check("rst_mid.C",         c,         0);
        check("rst_mid.cout",      cout,      0);
        check("rst_mid.ovf",       ovf,       0);
        check("rst_mid.in_ready",  in_ready,  1);
        tick();
        tick();
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("rst_mid.stale", seen, 0);
        run_op("post_rst", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);

        // Single-stage instance: latency 1
        a2 = 16'hFFFF; b2 = 16'h0001; sub2 = 1'b0; in_valid2 = 1'b1;
        #1;
        check("n16.in_ready", in_ready2, 1);
        tick();
        in_valid2 = 1'b0;
        check("n16.out_valid", out_valid2, 1);
        check("n16.C",         c2,         16'h0000);
        check("n16.cout",      cout2,      1);
        check("n16.ovf",       ovf2,       0);
        tick();
        check("n16.drained",   out_valid2, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined add/subtract unit: next generation of the catalog `adder` block. Splits an N-bit operation into K-bit carry-chained chunks, one chunk per pipeline stage, so wide adds close timing at high clock rates. Accepts one operation per cycle under a valid/ready handshake with backpressure. Reports carry-out and signed overflow. Sits in the catalog as a drop-in datapath adder for pipelined ALU and address-generation paths.

## Interface
- `n`, default 32: operand and result width in bits.
- `k`, default 8: chunk width per stage; `n % k == 0` required (elaboration error otherwise). `k == n` gives a single-stage registered adder.
- `STAGES`, derived `n/k`: pipeline depth; not overridable.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  operands on `A`, `B`, `sub` valid this cycle.
- `in_ready`  out  1  unit accepts operands this cycle.
- `A`  in  n  first operand.
- `B`  in  n  second operand.
- `sub`  in  1  0: C = A + B; 1: C = A − B.
- `out_valid`  out  1  result on `C`, `cout`, `ovf` valid.
- `out_ready`  in  1  consumer takes result this cycle.
- `C`  out  n  result.
- `cout`  out  1  carry out of bit n−1 (for subtract: 1 = no borrow).
- `ovf`  out  1  two's-complement signed overflow.

## Operation
- Effective B' = `sub` ? ~B : B; carry-in to chunk 0 = `sub`.
- Stage s (0..STAGES−1) adds chunk s of A and B' plus carry registered from stage s−1; 1 valid bit per stage.
- Operand chunks above s travel with the op (skew registers); result chunks below s travel with the op (deskew registers). Final stage register drives `C`, `cout`, `ovf` directly (no combinational path from inputs to outputs).
- `ovf` = carry into bit n−1 XOR carry out of bit n−1, computed in the last stage.
- Global advance enable `en = !out_valid || out_ready`. When `en` = 0 every stage holds (valid bits, data, carries). When `en` = 1 every stage shifts one position; bubbles (valid = 0) shift like data.
- `in_ready = en`. An op is accepted iff `in_valid && in_ready`; otherwise stage 0 loads valid = 0.
- Order preserved; no op dropped or duplicated.
- Reset: all valid bits 0; `out_valid` = 0, `C` = 0, `cout` = 0, `ovf` = 0; `in_ready` = 1 during and after reset. Reset mid-operation discards all in-flight ops; none emerge afterward.

## Timing
- Latency: op accepted at edge t appears with `out_valid` = 1 after edge t+STAGES−1, i.e. STAGES cycles (4 at defaults; 1 when `k == n`).
- Throughput: 1 op/cycle while `out_ready` = 1.
- `in_ready` is combinational from `out_valid` and `out_ready` only; no other combinational input-to-output path.
- While `out_valid && !out_ready`: `C`, `cout`, `ovf` held stable until the transfer cycle.
- Simultaneous accept and output transfer in the same cycle is legal and required for full throughput.
- Full pipeline with `out_ready` = 0: `in_ready` = 0; upstream must hold operands.

## Configuration
- `ADDER_PIPE_SAT_EN` defined: on `ovf` = 1, `C` saturates to signed limit: 0x7FF…F if A[n−1] = 0, 0x800…0 if A[n−1] = 1; `ovf` and `cout` still report the unsaturated result.
- Not defined: `C` wraps modulo 2^n; `ovf` reported only.

## Test plan
- Defaults, A=0xFFFFFFFF, B=0x00000001, sub=0, out_ready=1 -> 4 cycles later C=0x00000000, cout=1, ovf=0 (full carry ripple across all chunks).
- A=0x7FFFFFFF, B=0x00000001, sub=0 -> C=0x80000000, ovf=1, cout=0; with `ADDER_PIPE_SAT_EN`, C=0x7FFFFFFF, ovf=1.
- A=0x00000005, B=0x00000007, sub=1 -> C=0xFFFFFFFE, cout=0, ovf=0; A=0x80000000, B=1, sub=1 -> C=0x7FFFFFFF, ovf=1 (SAT: 0x80000000).
- 10 back-to-back random ops, out_ready dropped for 3 cycles mid-stream -> in_ready low exactly those cycles, outputs stable while stalled, all 10 results correct and in order vs. reference model.
- 3 ops in flight, assert rst asynchronously mid-cycle -> out_valid=0, C=0 immediately; after release no stale results appear, next op completes in 4 cycles.
- Rebuild with n=16, k=16 -> latency 1; A=0xFFFF, B=0x0001 -> C=0x0000, cout=1 next cycle.
